// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: datapath widths, opcode
// encodings, ALU function selects and the sequencer state encoding.
package alu_pkg;

   localparam int DW = 8;
   localparam int AW = 3;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;

   localparam logic [2:0] SEL_FWD = 3'b000;
   localparam logic [2:0] SEL_ADD = 3'b001;
   localparam logic [2:0] SEL_AND = 3'b010;
   localparam logic [2:0] SEL_OR  = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of every non-clock signal of the sequencer.
//   master : sequencer side (drives INSTR_READY, READREG*, ALU_*, WRITE*, flags)
//   slave  : environment side (fetch path, register file, ALU)
interface alu_op_sequencer_if
   import alu_pkg::*;
#(
   parameter int DATA_W = DW,
   parameter int REG_AW = AW
);
   logic [31:0]       INSTR;
   logic              INSTR_VALID;
   logic              INSTR_READY;
   logic [REG_AW-1:0] READREG1;
   logic [REG_AW-1:0] READREG2;
   logic [DATA_W-1:0] REG_OUT1;
   logic [DATA_W-1:0] REG_OUT2;
   logic [DATA_W-1:0] ALU_DATA1;
   logic [DATA_W-1:0] ALU_DATA2;
   logic [2:0]        ALU_SELECT;
   logic [DATA_W-1:0] ALU_RESULT;
   logic              ALU_ZERO;
   logic [REG_AW-1:0] WRITEREG;
   logic [DATA_W-1:0] WRITEDATA;
   logic              WRITEENABLE;
   logic              ZERO_FLAG;
   logic              ILLEGAL;

   modport master (
      input  INSTR, INSTR_VALID, REG_OUT1, REG_OUT2, ALU_RESULT, ALU_ZERO,
      output INSTR_READY, READREG1, READREG2, ALU_DATA1, ALU_DATA2, ALU_SELECT,
             WRITEREG, WRITEDATA, WRITEENABLE, ZERO_FLAG, ILLEGAL
   );

   modport slave (
      output INSTR, INSTR_VALID, REG_OUT1, REG_OUT2, ALU_RESULT, ALU_ZERO,
      input  INSTR_READY, READREG1, READREG2, ALU_DATA1, ALU_DATA2, ALU_SELECT,
             WRITEREG, WRITEDATA, WRITEENABLE, ZERO_FLAG, ILLEGAL
   );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
//   opcode  in  : instruction opcode byte
//   sel     out : ALU function select
//   imm_sel out : operand 2 comes from the immediate byte instead of REG_OUT2
//   negate  out : operand 2 is two's-complement negated (subtract via add)
//   illegal out : opcode is not defined
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [2:0] sel,
   output logic       imm_sel,
   output logic       negate,
   output logic       illegal
);

   always_comb begin
      sel     = SEL_FWD;
      imm_sel = 1'b0;
      negate  = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_LOADI: imm_sel = 1'b1;
         OP_MOV:   sel     = SEL_FWD;
         OP_ADD:   sel     = SEL_ADD;
         OP_SUB: begin
            sel    = SEL_ADD;
            negate = 1'b1;
         end
         OP_AND:   sel     = SEL_AND;
         OP_OR:    sel     = SEL_OR;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the 8-bit ALU. Accepts one instruction per
// valid/ready handshake, reads operands from the register file, drives the
// ALU for its fixed latency and issues a one-cycle register writeback.
//   CLK   in : clock, rising edge
//   RESET in : synchronous active-low reset
//   bus      : master side of alu_op_sequencer_if (fetch, regfile, ALU)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a new instruction; ALU inputs hold last values
// READ  | regfile read of the latched instruction; form ALU operands
// EXEC  | ALU inputs held; latency counter runs down to 1
// WB    | one-cycle writeback of ALU_RESULT; capture ALU_ZERO
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W   = DW,
   parameter int REG_AW   = AW,
   parameter int LAT_FAST = 1,
   parameter int LAT_ADD  = 2
) (
   input logic                CLK,
   input logic                RESET,
   alu_op_sequencer_if.master bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_READ = READ;
   localparam logic [1:0] S_EXEC = EXEC;
   localparam logic [1:0] S_WB   = WB;

   logic [1:0]        state;
   logic [7:0]        op_q;
   logic [REG_AW-1:0] dest_q;
   logic [REG_AW-1:0] src1_q;
   logic [7:0]        imm_q;
   logic [3:0]        cnt;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;
   logic [2:0]        sel;
   logic              zero_q;
   logic              ill_q;

   logic [2:0]        dec_sel;
   logic              dec_imm;
   logic              dec_neg;
   logic              dec_ill;
   logic [DATA_W-1:0] base2;
   logic [DATA_W-1:0] operand2;
   logic [3:0]        lat_load;

   alu_op_decode u_decode (
      .opcode  (op_q),
      .sel     (dec_sel),
      .imm_sel (dec_imm),
      .negate  (dec_neg),
      .illegal (dec_ill)
   );

   always_comb begin
      base2    = dec_imm ? DATA_W'(imm_q) : bus.REG_OUT2;
      operand2 = dec_neg ? (~base2 + DATA_W'(1)) : base2;
      lat_load = (dec_sel == SEL_ADD) ? 4'(LAT_ADD) : 4'(LAT_FAST);
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state  <= S_IDLE;
         op_q   <= '0;
         dest_q <= '0;
         src1_q <= '0;
         imm_q  <= '0;
         cnt    <= '0;
         data1  <= '0;
         data2  <= '0;
         sel    <= SEL_FWD;
         zero_q <= 1'b0;
         ill_q  <= 1'b0;
      end else begin
         ill_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.INSTR_VALID && bus.INSTR_READY) begin
                  op_q   <= bus.INSTR[31:24];
                  dest_q <= bus.INSTR[16 +: REG_AW];
                  src1_q <= bus.INSTR[8 +: REG_AW];
                  imm_q  <= bus.INSTR[7:0];
                  state  <= S_READ;
               end
            end
            S_READ: begin
               if (dec_ill) begin
                  ill_q <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  data1 <= bus.REG_OUT1;
                  data2 <= operand2;
                  sel   <= dec_sel;
                  cnt   <= lat_load;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt == 4'd1) state <= S_WB;
               else             cnt   <= cnt - 4'd1;
            end
            S_WB: begin
               zero_q <= bus.ALU_ZERO;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Ready is withheld during the ILLEGAL pulse so a rejected instruction
   // costs the same turnaround as a zero-latency operation.
   assign bus.INSTR_READY = (state == S_IDLE) && !ill_q;
   assign bus.READREG1    = src1_q;
   assign bus.READREG2    = imm_q[REG_AW-1:0];
   assign bus.ALU_DATA1   = data1;
   assign bus.ALU_DATA2   = data2;
   assign bus.ALU_SELECT  = sel;
   assign bus.WRITEREG    = dest_q;
   assign bus.WRITEENABLE = (state == S_WB);
   assign bus.WRITEDATA   = (state == S_WB) ? bus.ALU_RESULT : '0;
   assign bus.ZERO_FLAG   = zero_q;
   assign bus.ILLEGAL     = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
   import alu_pkg::*;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   armed = 1'b0;

   logic [7:0] rf   [8] = '{default: 8'h00};
   logic [7:0] rf_m [8] = '{default: 8'h00};
   logic [7:0] alu_res;

   alu_op_sequencer_if bus ();

   alu_op_sequencer dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // environment: asynchronous register file and combinational ALU
   assign bus.REG_OUT1 = rf[bus.READREG1];
   assign bus.REG_OUT2 = rf[bus.READREG2];

   always_comb begin
      alu_res = 8'h00;
      case (bus.ALU_SELECT)
         3'b000:  alu_res = bus.ALU_DATA2;
         3'b001:  alu_res = bus.ALU_DATA1 + bus.ALU_DATA2;
         3'b010:  alu_res = bus.ALU_DATA1 & bus.ALU_DATA2;
         3'b011:  alu_res = bus.ALU_DATA1 | bus.ALU_DATA2;
         default: alu_res = 8'h00;
      endcase
   end

   assign bus.ALU_RESULT = alu_res;
   assign bus.ALU_ZERO   = (alu_res == 8'h00);

   always @(posedge CLK) if (bus.WRITEENABLE) rf[bus.WRITEREG] <= bus.WRITEDATA;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(input logic [7:0] op, input int d, input int s1, input int s2);
      return {op, 8'(d), 8'(s1), 8'(s2)};
   endfunction

   // behavioural reference: what each opcode writes back
   function automatic logic [7:0] ref_result(input logic [7:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] imm);
      case (op)
         8'h00:   return imm;
         8'h01:   return b;
         8'h02:   return a + b;
         8'h03:   return a - b;
         8'h04:   return a & b;
         8'h05:   return a | b;
         default: return 8'h00;
      endcase
   endfunction

   // model state
   int         m_cyc  = 0;
   int         m_h    = 0;
   int         m_busy = -1;
   int         m_lat  = 0;
   bit         m_act  = 1'b0;
   bit         m_legal;
   logic [7:0] m_op, m_a, m_b, m_imm, m_d2, m_res;
   logic [2:0] m_dest, m_sel;
   logic       m_zf   = 1'b0;
   bit         exp_we, exp_ill;

   initial begin : compare
      forever begin
         @(negedge CLK);
         if (armed) begin
            exp_we  = 1'b0;
            exp_ill = 1'b0;
            chk("ready", 32'(bus.INSTR_READY), 32'(m_cyc > m_busy));
            if (m_act) begin
               if (!m_legal) begin
                  if (m_cyc == m_h + 2) exp_ill = 1'b1;
               end else begin
                  if (m_cyc >= m_h + 2 && m_cyc <= m_h + 1 + m_lat) begin
                     chk("exec_sel",   32'(bus.ALU_SELECT), 32'(m_sel));
                     chk("exec_data1", 32'(bus.ALU_DATA1),  32'(m_a));
                     chk("exec_data2", 32'(bus.ALU_DATA2),  32'(m_d2));
                  end
                  if (m_cyc == m_h + 2 + m_lat) begin
                     exp_we = 1'b1;
                     chk("wb_data", 32'(bus.WRITEDATA), 32'(m_res));
                     chk("wb_reg",  32'(bus.WRITEREG),  32'(m_dest));
                  end
               end
            end
            chk("writeenable", 32'(bus.WRITEENABLE), 32'(exp_we));
            chk("illegal",     32'(bus.ILLEGAL),     32'(exp_ill));
            chk("zero_flag",   32'(bus.ZERO_FLAG),   32'(m_zf));

            if (m_act && m_cyc == m_h + 2 + m_lat) begin
               if (m_legal) begin
                  rf_m[m_dest] = m_res;
                  m_zf = (m_res == 8'h00);
               end
               m_act = 1'b0;
            end

            if (RESET && bus.INSTR_VALID && m_cyc > m_busy) begin
               m_op    = bus.INSTR[31:24];
               m_a     = rf_m[bus.INSTR[10:8]];
               m_b     = rf_m[bus.INSTR[2:0]];
               m_imm   = bus.INSTR[7:0];
               m_dest  = bus.INSTR[18:16];
               m_legal = (m_op <= 8'h05);
               m_lat   = !m_legal ? 0 : (m_op == 8'h02 || m_op == 8'h03) ? 2 : 1;
               m_sel   = (m_op == 8'h04) ? 3'd2 : (m_op == 8'h05) ? 3'd3 :
                         (m_op == 8'h02 || m_op == 8'h03) ? 3'd1 : 3'd0;
               m_d2    = (m_op == 8'h00) ? m_imm : (m_op == 8'h03) ? 8'h00 - m_b : m_b;
               m_res   = ref_result(m_op, m_a, m_b, m_imm);
               m_h     = m_cyc;
               m_busy  = m_cyc + 2 + m_lat;
               m_act   = 1'b1;
            end

            if (!RESET) begin
               m_act  = 1'b0;
               m_busy = m_cyc;
               m_zf   = 1'b0;
            end
         end
         m_cyc++;
      end
   end

   // Present instructions in order; VALID stays high back-to-back unless a
   // random gap is requested. Returns one cycle after the last acceptance.
   task automatic stream(input logic [31:0] ins[$], input bit rnd_gap);
      int  n;
      int  k;
      bit  aligned;
      aligned = 1'b0;
      foreach (ins[i]) begin
         n = rnd_gap ? int'($urandom_range(0, 2)) : 0;
         if (n > 0) bus.INSTR_VALID = 1'b0;
         if (!aligned || n > 0) begin
            repeat ((n > 0) ? n : 1) @(posedge CLK);
            #1;
         end
         bus.INSTR       = ins[i];
         bus.INSTR_VALID = 1'b1;
         for (k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (bus.INSTR_READY) break;
         end
         if (k == 40) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no INSTR_READY in 40 cycles, want acceptance");
         end
         @(posedge CLK);
         #1;
         aligned = 1'b1;
      end
      bus.INSTR_VALID = 1'b0;
   endtask

   task automatic measure(input string nm, input logic [31:0] ins, input int exp_lat,
                          input bit exp_ill, input logic [2:0] exp_sel, input logic [7:0] exp_d2,
                          input logic [7:0] exp_data, input logic exp_zf);
      logic [31:0] one[$];
      int          k;
      bit          seen;
      one.push_back(ins);
      seen = 1'b0;
      stream(one, 1'b0);
      for (k = 1; k <= 12; k++) begin
         @(negedge CLK);
         if (!exp_ill && k >= 2 && k < exp_lat) begin
            chk({nm, "_sel"}, 32'(bus.ALU_SELECT), 32'(exp_sel));
            chk({nm, "_d2"},  32'(bus.ALU_DATA2),  32'(exp_d2));
         end
         if (bus.WRITEENABLE || bus.ILLEGAL) begin
            seen = 1'b1;
            break;
         end
      end
      chk({nm, "_latency"}, seen ? 32'(k) : 32'd0, 32'(exp_lat));
      if (seen) begin
         if (exp_ill) begin
            chk({nm, "_illegal"}, 32'(bus.ILLEGAL), 32'd1);
            chk({nm, "_no_we"},   32'(bus.WRITEENABLE), 32'd0);
         end else begin
            chk({nm, "_data"}, 32'(bus.WRITEDATA), 32'(exp_data));
            chk({nm, "_reg"},  32'(bus.WRITEREG),  32'(ins[18:16]));
         end
      end
      @(negedge CLK);
      chk({nm, "_ready_after"}, 32'(bus.INSTR_READY), 32'd1);
      chk({nm, "_zf"},          32'(bus.ZERO_FLAG),   32'(exp_zf));
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [7:0] op;
      int         pick;
      pick = int'($urandom_range(0, 7));
      op   = (pick < 6) ? 8'(pick) : 8'($urandom_range(6, 255));
      return {op, 8'($urandom), 8'($urandom), 8'($urandom)};
   endfunction

   initial begin : main
      logic [31:0] q[$];
      bus.INSTR       = '0;
      bus.INSTR_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b1;
      armed = 1'b1;
      @(negedge CLK);
      chk("rst_ready", 32'(bus.INSTR_READY), 32'd1);
      chk("rst_we",    32'(bus.WRITEENABLE), 32'd0);
      chk("rst_sel",   32'(bus.ALU_SELECT),  32'd0);
      chk("rst_d1",    32'(bus.ALU_DATA1),   32'd0);

      measure("loadi",  enc(OP_LOADI, 1, 0, 8'h2A), 3, 1'b0, 3'b000, 8'h2A, 8'h2A, 1'b0);
      measure("ld_r1",  enc(OP_LOADI, 1, 0, 8'h05), 3, 1'b0, 3'b000, 8'h05, 8'h05, 1'b0);
      measure("ld_r2",  enc(OP_LOADI, 2, 0, 8'h07), 3, 1'b0, 3'b000, 8'h07, 8'h07, 1'b0);
      measure("add",    enc(OP_ADD, 3, 1, 2),       4, 1'b0, 3'b001, 8'h07, 8'h0C, 1'b0);
      measure("ld_r2b", enc(OP_LOADI, 2, 0, 8'h05), 3, 1'b0, 3'b000, 8'h05, 8'h05, 1'b0);
      measure("sub",    enc(OP_SUB, 4, 1, 2),       4, 1'b0, 3'b001, 8'hFB, 8'h00, 1'b1);
      measure("ld_ff",  enc(OP_LOADI, 1, 0, 8'hFF), 3, 1'b0, 3'b000, 8'hFF, 8'hFF, 1'b0);
      measure("ld_01",  enc(OP_LOADI, 2, 0, 8'h01), 3, 1'b0, 3'b000, 8'h01, 8'h01, 1'b0);
      measure("addwrap",enc(OP_ADD, 5, 1, 2),       4, 1'b0, 3'b001, 8'h01, 8'h00, 1'b1);
      measure("illop",  enc(8'h09, 6, 1, 2),        2, 1'b1, 3'b000, 8'h00, 8'h00, 1'b1);
      measure("ld_00",  enc(OP_LOADI, 2, 0, 8'h00), 3, 1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
      measure("sub00",  enc(OP_SUB, 6, 1, 2),       4, 1'b0, 3'b001, 8'h00, 8'hFF, 1'b0);
      measure("ld_80",  enc(OP_LOADI, 2, 0, 8'h80), 3, 1'b0, 3'b000, 8'h80, 8'h80, 1'b0);
      measure("sub80",  enc(OP_SUB, 6, 1, 2),       4, 1'b0, 3'b001, 8'h80, 8'h7F, 1'b0);
      measure("and",    enc(OP_AND, 4, 1, 2),       3, 1'b0, 3'b010, 8'h80, 8'h80, 1'b0);

      // reset while the add is in EXEC
      q = {enc(OP_ADD, 7, 1, 2)};
      stream(q, 1'b0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(negedge CLK);
      chk("rstx_ready", 32'(bus.INSTR_READY), 32'd1);
      chk("rstx_we",    32'(bus.WRITEENABLE), 32'd0);
      chk("rstx_d1",    32'(bus.ALU_DATA1),   32'd0);
      chk("rstx_d2",    32'(bus.ALU_DATA2),   32'd0);
      chk("rstx_sel",   32'(bus.ALU_SELECT),  32'd0);
      chk("rstx_wreg",  32'(bus.WRITEREG),    32'd0);
      chk("rstx_rreg1", 32'(bus.READREG1),    32'd0);
      chk("rstx_zf",    32'(bus.ZERO_FLAG),   32'd0);
      repeat (6) @(negedge CLK);
      chk("rstx_r7_unwritten", 32'(rf[7]), 32'd0);

      // VALID held high across three queued instructions
      q = {enc(OP_LOADI, 1, 0, 8'h11), enc(OP_LOADI, 2, 0, 8'h22), enc(OP_OR, 3, 1, 2)};
      stream(q, 1'b0);
      repeat (6) @(negedge CLK);
      chk("queue_r1", 32'(rf[1]), 32'h11);
      chk("queue_r3", 32'(rf[3]), 32'h33);

      // randomized traffic, with and without idle gaps
      for (int s = 0; s < 4; s++) begin
         q = {};
         for (int i = 0; i < 20; i++) q.push_back(rnd_instr());
         stream(q, s[0]);
      end
      repeat (10) @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
